// File: rtl/fsm_frame_chk.sv
// Per-channel packet framing checker: tracks head/data/tail beats on NUM_CH channels and flags framing errors.
// done/err are registered one cycle after the causing beat; no backpressure, every beat is consumed.
module fsm_frame_chk #(
  parameter int NUM_CH  = 4,
  parameter int LEN_W   = 8,
  parameter int MAX_LEN = 16,
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              valid,
  input  logic              head,
  input  logic              tail,
  input  logic [CH_W-1:0]   ch,
  input  logic              flush,
  output logic              done,
  output logic [CH_W-1:0]   done_ch,
  output logic [LEN_W-1:0]  done_len,
  output logic              err,
  output logic [CH_W-1:0]   err_ch,
  output logic [2:0]        err_code,
  output logic [NUM_CH-1:0] busy
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HEAD = 3'd1,
    ST_DATA = 3'd2,
    ST_TAIL = 3'd3,
    ST_ERR  = 3'd4
  } state_e;

  localparam logic [2:0]     ERR_ORPHAN  = 3'd1;
  localparam logic [2:0]     ERR_NESTED  = 3'd2;
  localparam logic [2:0]     ERR_OVERLEN = 3'd3;
  localparam logic [2:0]     ERR_BADCH   = 3'd4;
  localparam logic [CH_W:0]  NUM_CH_C    = (CH_W+1)'(NUM_CH);
  localparam logic [LEN_W:0] MAX_LEN_C   = (LEN_W+1)'(MAX_LEN);

  state_e             st_q  [NUM_CH];
  state_e             st_d  [NUM_CH];
  logic [LEN_W-1:0]   len_q [NUM_CH];
  logic [LEN_W-1:0]   len_d [NUM_CH];
  logic               done_q, done_d;
  logic [CH_W-1:0]    done_ch_q, done_ch_d;
  logic [LEN_W-1:0]   done_len_q, done_len_d;
  logic               err_q, err_d;
  logic [CH_W-1:0]    err_ch_q, err_ch_d;
  logic [2:0]         err_code_q, err_code_d;
  logic               in_range;
  logic               hit;
  logic [LEN_W:0]     len_inc;

  assign in_range = ({1'b0, ch} < NUM_CH_C);

  always_comb begin
    st_d       = st_q;
    len_d      = len_q;
    done_d     = 1'b0;
    done_ch_d  = done_ch_q;
    done_len_d = done_len_q;
    err_d      = 1'b0;
    err_ch_d   = err_ch_q;
    err_code_d = err_code_q;
    hit        = 1'b0;
    len_inc    = '0;
    if (flush) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_d[i]  = ST_IDLE;
        len_d[i] = '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        hit     = valid && in_range && (ch == CH_W'(i));
        len_inc = {1'b0, len_q[i]} + (LEN_W+1)'(1);
        if (!hit) begin
          case (st_q[i])
            ST_HEAD: st_d[i] = ST_DATA;
            ST_TAIL: st_d[i] = ST_IDLE;
            ST_IDLE, ST_DATA, ST_ERR: st_d[i] = st_q[i];
            default: st_d[i] = ST_IDLE;
          endcase
        end else begin
          case (st_q[i])
            ST_IDLE, ST_TAIL: begin
              if (head && tail) begin
                st_d[i]    = ST_TAIL;
                len_d[i]   = LEN_W'(1);
                done_d     = 1'b1;
                done_ch_d  = ch;
                done_len_d = LEN_W'(1);
              end else if (head) begin
                st_d[i]  = ST_HEAD;
                len_d[i] = LEN_W'(1);
              end else begin
                st_d[i]    = ST_IDLE;
                err_d      = 1'b1;
                err_ch_d   = ch;
                err_code_d = ERR_ORPHAN;
              end
            end
            ST_HEAD, ST_DATA: begin
              if (head) begin
                st_d[i]    = ST_ERR;
                err_d      = 1'b1;
                err_ch_d   = ch;
                err_code_d = ERR_NESTED;
              end else if (len_inc > MAX_LEN_C) begin
                // Overlength wins even if this beat is also the tail.
                st_d[i]    = ST_ERR;
                err_d      = 1'b1;
                err_ch_d   = ch;
                err_code_d = ERR_OVERLEN;
              end else begin
                len_d[i] = len_inc[LEN_W-1:0];
                if (tail) begin
                  st_d[i]    = ST_TAIL;
                  done_d     = 1'b1;
                  done_ch_d  = ch;
                  done_len_d = len_inc[LEN_W-1:0];
                end else begin
                  st_d[i] = ST_DATA;
                end
              end
            end
            ST_ERR: begin
              if (tail) begin
                st_d[i] = ST_IDLE;
              end else if (head) begin
                st_d[i]  = ST_HEAD;
                len_d[i] = LEN_W'(1);
              end
            end
            default: st_d[i] = ST_IDLE;
          endcase
        end
      end
      if (valid && !in_range) begin
        err_d      = 1'b1;
        err_ch_d   = ch;
        err_code_d = ERR_BADCH;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        st_q[i]  <= ST_IDLE;
        len_q[i] <= '0;
      end
      done_q     <= 1'b0;
      done_ch_q  <= '0;
      done_len_q <= '0;
      err_q      <= 1'b0;
      err_ch_q   <= '0;
      err_code_q <= '0;
    end else begin
      st_q       <= st_d;
      len_q      <= len_d;
      done_q     <= done_d;
      done_ch_q  <= done_ch_d;
      done_len_q <= done_len_d;
      err_q      <= err_d;
      err_ch_q   <= err_ch_d;
      err_code_q <= err_code_d;
    end
  end

  always_comb begin
    busy = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      busy[i] = (st_q[i] == ST_HEAD) || (st_q[i] == ST_DATA) || (st_q[i] == ST_ERR);
    end
  end

  assign done     = done_q;
  assign done_ch  = done_ch_q;
  assign done_len = done_len_q;
  assign err      = err_q;
  assign err_ch   = err_ch_q;
  assign err_code = err_code_q;

endmodule

// File: tb/tb_fsm_frame_chk.sv
// Scoreboard bench for fsm_frame_chk: default 4-channel instance plus a 3-channel instance for bad-channel beats.
module tb_fsm_frame_chk;

  logic       clock = 1'b0;
  logic       reset;
  logic       valid, head, tail, flush, valid3;
  logic [1:0] ch;

  logic       done, err;
  logic [1:0] done_ch, err_ch;
  logic [7:0] done_len;
  logic [2:0] err_code;
  logic [3:0] busy;

  logic       done3, err3;
  logic [1:0] done_ch3, err_ch3;
  logic [7:0] done_len3;
  logic [2:0] err_code3;
  logic [2:0] busy3;

  fsm_frame_chk u_dut (
    .clock(clock), .reset(reset), .valid(valid), .head(head), .tail(tail),
    .ch(ch), .flush(flush), .done(done), .done_ch(done_ch), .done_len(done_len),
    .err(err), .err_ch(err_ch), .err_code(err_code), .busy(busy)
  );

  fsm_frame_chk #(.NUM_CH(3)) u_dut3 (
    .clock(clock), .reset(reset), .valid(valid3), .head(head), .tail(tail),
    .ch(ch), .flush(flush), .done(done3), .done_ch(done_ch3), .done_len(done_len3),
    .err(err3), .err_ch(err_ch3), .err_code(err_code3), .busy(busy3)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    int         kind;   // 0 none, 1 done, 2 err
    int         ch;
    int         val;    // length for done, code for err
    logic [3:0] busy;
  } exp_t;

  exp_t sb[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic v, input logic h, input logic t, input logic [1:0] c,
                      input logic f, input int ek, input int ev, input logic [3:0] eb);
    exp_t e;
    valid = v; head = h; tail = t; ch = c; flush = f;
    e.kind = ek; e.ch = int'(c); e.val = ev; e.busy = eb;
    sb.push_back(e);
    @(posedge clock);
    #1;
    e = sb.pop_front();
    check("done", 32'(done), 32'(e.kind == 1));
    check("err", 32'(err), 32'(e.kind == 2));
    if (e.kind == 1) begin
      check("done_ch", 32'(done_ch), 32'(e.ch));
      check("done_len", 32'(done_len), 32'(e.val));
    end
    if (e.kind == 2) begin
      check("err_ch", 32'(err_ch), 32'(e.ch));
      check("err_code", 32'(err_code), 32'(e.val));
    end
    check("busy", 32'(busy), 32'(e.busy));
    valid = 1'b0; head = 1'b0; tail = 1'b0; flush = 1'b0;
  endtask

  initial begin
    reset = 1'b0; valid = 1'b0; head = 1'b0; tail = 1'b0; flush = 1'b0;
    valid3 = 1'b0; ch = 2'd0;
    #2 reset = 1'b1;
    #1;
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_done_ch", 32'(done_ch), 32'd0);
    check("rst_done_len", 32'(done_len), 32'd0);
    check("rst_err_ch", 32'(err_ch), 32'd0);
    check("rst_err_code", 32'(err_code), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset = 1'b0;

    // ch0 four-beat packet
    step(1, 1, 0, 2'd0, 0, 0, 0, 4'b0001);
    step(1, 0, 0, 2'd0, 0, 0, 0, 4'b0001);
    step(1, 0, 0, 2'd0, 0, 0, 0, 4'b0001);
    step(1, 0, 1, 2'd0, 0, 1, 4, 4'b0000);
    step(0, 0, 0, 2'd0, 0, 0, 0, 4'b0000);
    check("hold_done_ch", 32'(done_ch), 32'd0);
    check("hold_done_len", 32'(done_len), 32'd4);

    // single-beat packet on ch2
    step(1, 1, 1, 2'd2, 0, 1, 1, 4'b0000);
    step(0, 0, 0, 2'd0, 0, 0, 0, 4'b0000);

    // interleaved ch1 / ch3
    step(1, 1, 0, 2'd1, 0, 0, 0, 4'b0010);
    step(1, 1, 0, 2'd3, 0, 0, 0, 4'b1010);
    step(1, 0, 1, 2'd1, 0, 1, 2, 4'b1000);
    step(1, 0, 0, 2'd3, 0, 0, 0, 4'b1000);
    step(1, 0, 1, 2'd3, 0, 1, 3, 4'b0000);

    // overlength: head + 16 non-tail beats, then tail clears without done
    step(1, 1, 0, 2'd0, 0, 0, 0, 4'b0001);
    for (int i = 0; i < 15; i++) step(1, 0, 0, 2'd0, 0, 0, 0, 4'b0001);
    step(1, 0, 0, 2'd0, 0, 2, 3, 4'b0001);
    step(1, 0, 1, 2'd0, 0, 0, 0, 4'b0000);

    // nested head, recovery via head from ERR, then orphan on ch0
    step(1, 1, 0, 2'd1, 0, 0, 0, 4'b0010);
    step(1, 1, 0, 2'd1, 0, 2, 2, 4'b0010);
    step(1, 1, 0, 2'd1, 0, 0, 0, 4'b0010);
    step(1, 0, 1, 2'd1, 0, 1, 2, 4'b0000);
    step(1, 0, 0, 2'd0, 0, 2, 1, 4'b0000);
    step(0, 0, 0, 2'd0, 0, 0, 0, 4'b0000);
    check("hold_err_ch", 32'(err_ch), 32'd0);
    check("hold_err_code", 32'(err_code), 32'd1);

    // bad channel on the 3-channel instance
    valid3 = 1'b1; head = 1'b1; tail = 1'b1; ch = 2'd3;
    @(posedge clock);
    #1;
    check("badch_err", 32'(err3), 32'd1);
    check("badch_done", 32'(done3), 32'd0);
    check("badch_err_ch", 32'(err_ch3), 32'd3);
    check("badch_code", 32'(err_code3), 32'd4);
    check("badch_busy", 32'(busy3), 32'd0);
    valid3 = 1'b0; head = 1'b0; tail = 1'b0; ch = 2'd0;

    // flush with same-cycle tail drops the beat
    step(1, 1, 0, 2'd0, 0, 0, 0, 4'b0001);
    step(1, 0, 0, 2'd0, 0, 0, 0, 4'b0001);
    step(1, 0, 1, 2'd0, 1, 0, 0, 4'b0000);
    step(1, 0, 0, 2'd0, 0, 2, 1, 4'b0000);

    // async reset mid-packet on ch2
    step(1, 1, 0, 2'd2, 0, 0, 0, 4'b0100);
    step(1, 0, 0, 2'd2, 0, 0, 0, 4'b0100);
    #2 reset = 1'b1;
    #1;
    check("arst_done_ch", 32'(done_ch), 32'd0);
    check("arst_done_len", 32'(done_len), 32'd0);
    check("arst_err_ch", 32'(err_ch), 32'd0);
    check("arst_err_code", 32'(err_code), 32'd0);
    check("arst_busy", 32'(busy), 32'd0);
    #1 reset = 1'b0;
    step(0, 0, 0, 2'd0, 0, 0, 0, 4'b0000);
    step(1, 0, 1, 2'd2, 0, 2, 1, 4'b0000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
